// File: rtl/mod_add_arb_if.sv
// Requester-side bus of the shared modular-adder arbiter: per-requester
// operand handshakes, the one-hot result strobe and the busy flag.
interface mod_add_arb_if #(
    parameter int NB_REQ = 4,
    parameter int OP_W   = 64
);
    logic [NB_REQ-1:0]      req_vld;
    logic [NB_REQ-1:0]      req_rdy;
    logic [NB_REQ*OP_W-1:0] req_a;
    logic [NB_REQ*OP_W-1:0] req_b;
    logic [NB_REQ-1:0]      rsp_avail;
    logic [OP_W-1:0]        rsp_z;
    logic                   busy;

    modport master (
        output req_vld, req_a, req_b,
        input  req_rdy, rsp_avail, rsp_z, busy
    );

    modport slave (
        input  req_vld, req_a, req_b,
        output req_rdy, rsp_avail, rsp_z, busy
    );
endinterface

// File: rtl/mod_add_arb.sv
// Shared pipelined modular adder (z = a + b mod MOD_M) and the round-robin
// arbiter that feeds it from NB_REQ requesters with per-requester credits.

module mod_add #(
    parameter int              OP_W     = 64,
    parameter logic [OP_W-1:0] MOD_M    = {OP_W{1'b1}} - (OP_W'(1) << (OP_W / 2)) + OP_W'(2),
    parameter int              IN_PIPE  = 1,
    parameter int              OUT_PIPE = 1,
    parameter int              SIDE_W   = 2
) (
    input  logic              clk,
    input  logic              s_rst_n,
    input  logic              in_avail,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_avail,
    output logic [OP_W-1:0]   out_z,
    output logic [SIDE_W-1:0] out_side
);
    // Single conditional subtraction; the sum keeps its carry so a+b up to
    // 2*MOD_M-2 is reduced correctly.
    function automatic logic [OP_W-1:0] mod_reduce(input logic [OP_W:0] s);
        logic [OP_W:0] d;
        d = s - {1'b0, MOD_M};
        return (s >= {1'b0, MOD_M}) ? d[OP_W-1:0] : s[OP_W-1:0];
    endfunction

    logic              vld_p0;
    logic [OP_W-1:0]   a_p0;
    logic [OP_W-1:0]   b_p0;
    logic [SIDE_W-1:0] side_p0;
    logic [OP_W-1:0]   z_p0;

    // ---- stage p0: optional operand register ----
    if (IN_PIPE != 0) begin : g_in_reg
        // Valid is the only reset bit in the input stage.
        always_ff @(posedge clk or negedge s_rst_n) begin
            if (!s_rst_n) vld_p0 <= 1'b0;
            else          vld_p0 <= in_avail;
        end
        // Operand and side-channel data, not reset.
        always_ff @(posedge clk) begin
            a_p0    <= in_a;
            b_p0    <= in_b;
            side_p0 <= in_side;
        end
    end else begin : g_in_comb
        // Pass-through when the input register is disabled.
        always_comb begin
            vld_p0  = in_avail;
            a_p0    = in_a;
            b_p0    = in_b;
            side_p0 = in_side;
        end
    end

    // Modular sum of the stage-p0 operands.
    always_comb begin
        z_p0 = mod_reduce({1'b0, a_p0} + {1'b0, b_p0});
    end

    // ---- stage p1: optional result register ----
    if (OUT_PIPE != 0) begin : g_out_reg
        // Result valid, cleared by reset so in-flight work is dropped.
        always_ff @(posedge clk or negedge s_rst_n) begin
            if (!s_rst_n) out_avail <= 1'b0;
            else          out_avail <= vld_p0;
        end
        // Result data and tag, not reset.
        always_ff @(posedge clk) begin
            out_z    <= z_p0;
            out_side <= side_p0;
        end
    end else begin : g_out_comb
        // Pass-through when the output register is disabled.
        always_comb begin
            out_avail = vld_p0;
            out_z     = z_p0;
            out_side  = side_p0;
        end
    end
endmodule

module mod_add_arb #(
    parameter int              OP_W         = 64,
    parameter logic [OP_W-1:0] MOD_M        = {OP_W{1'b1}} - (OP_W'(1) << (OP_W / 2)) + OP_W'(2),
    parameter int              NB_REQ       = 4,
    parameter int              IN_PIPE      = 1,
    parameter int              OUT_PIPE     = 1,
    parameter int              MAX_INFLIGHT = 4
) (
    input  logic         clk,
    input  logic         s_rst_n,
    mod_add_arb_if.slave bus
);
    localparam int SIDE_W = $clog2(NB_REQ);
    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0]  cnt [NB_REQ];
    logic [NB_REQ-1:0] elig;
    logic [NB_REQ-1:0] grant;
    logic [NB_REQ-1:0] rsp_hot;
    logic [SIDE_W-1:0] rr_ptr;
    logic [SIDE_W-1:0] gnt_idx;
    logic [SIDE_W-1:0] cand;
    logic              gnt_any;
    int                pos;
    logic [OP_W-1:0]   sel_a;
    logic [OP_W-1:0]   sel_b;
    logic              busy_w;

    logic              vld_p0;
    logic [OP_W-1:0]   a_p0;
    logic [OP_W-1:0]   b_p0;
    logic [SIDE_W-1:0] tag_p0;

    logic              add_vld;
    logic [OP_W-1:0]   add_z;
    logic [SIDE_W-1:0] add_side;

    // Eligibility uses the registered credit count only, so a requester at
    // its limit waits one cycle after its result returns.
    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            elig[i] = bus.req_vld[i] && (cnt[i] < CNT_W'(MAX_INFLIGHT));
        end
    end

    // Round-robin search starting at rr_ptr; at most one grant per cycle.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        pos     = 0;
        cand    = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NB_REQ) pos = pos - NB_REQ;
            cand = SIDE_W'(pos);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    // Select the granted requester's operand pair.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_a[i*OP_W +: OP_W];
                sel_b = bus.req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody is granted.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n)     rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= (gnt_idx == SIDE_W'(NB_REQ - 1)) ? '0 : gnt_idx + SIDE_W'(1);
    end

    // ---- stage p0: issue register in front of the adder ----
    // Issue valid.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) vld_p0 <= 1'b0;
        else          vld_p0 <= gnt_any;
    end

    // Issue operands and tag, captured only on a handshake.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            a_p0   <= sel_a;
            b_p0   <= sel_b;
            tag_p0 <= gnt_idx;
        end
    end

    mod_add #(
        .OP_W     (OP_W),
        .MOD_M    (MOD_M),
        .IN_PIPE  (IN_PIPE),
        .OUT_PIPE (OUT_PIPE),
        .SIDE_W   (SIDE_W)
    ) u_mod_add (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .in_avail  (vld_p0),
        .in_a      (a_p0),
        .in_b      (b_p0),
        .in_side   (tag_p0),
        .out_avail (add_vld),
        .out_z     (add_z),
        .out_side  (add_side)
    );

    // ---- return: tag from the side channel routes the result ----
    always_comb begin
        rsp_hot = add_vld ? (NB_REQ'(1) << add_side) : '0;
    end

    // Credit counters: grant adds, returned result subtracts, both cancel.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < NB_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB_REQ; i++) begin
                case ({grant[i], rsp_hot[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Busy while any requester has work outstanding.
    always_comb begin
        busy_w = 1'b0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (cnt[i] != '0) busy_w = 1'b1;
        end
    end

    assign bus.req_rdy   = grant;
    assign bus.rsp_avail = rsp_hot;
    assign bus.rsp_z     = add_z;
    assign bus.busy      = busy_w;

    for (genvar i = 0; i < NB_REQ; i++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (!s_rst_n)
            !(grant[i] && !rsp_hot[i] && cnt[i] == CNT_W'(MAX_INFLIGHT)));
        a_no_underflow: assert property (@(posedge clk) disable iff (!s_rst_n)
            !(rsp_hot[i] && !grant[i] && cnt[i] == '0));
    end
endmodule

// File: tb/tb_mod_add_arb.sv
// Bench for mod_add_arb: 8-bit operands, MOD_M = 251, four requesters,
// two credits each. A transaction-level model predicts grants, results,
// result timing and busy every cycle.
module tb_mod_add_arb;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int M   = 251;
    localparam int MAX = 2;
    localparam int LAT = 3;

    logic clk;
    logic s_rst_n;

    mod_add_arb_if #(.NB_REQ(N), .OP_W(W)) bus ();

    mod_add_arb #(
        .OP_W         (W),
        .MOD_M        (8'd251),
        .NB_REQ       (N),
        .IN_PIPE      (1),
        .OUT_PIPE     (1),
        .MAX_INFLIGHT (MAX)
    ) dut (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int z;
        int due;
    } op_t;

    op_t        pend[$];
    int         m_cnt[N];
    int         m_rr;
    int         cyc;
    int         checks;
    int         errors;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rsp;
    logic [7:0] exp_z;
    logic [7:0] got_z;
    logic       exp_busy;

    function automatic void model_reset();
        pend.delete();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr = 0;
    endfunction

    // Expected outputs for the current cycle from model state and inputs.
    function automatic void predict();
        exp_rdy = '0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (exp_rdy == 4'b0000 && bus.req_vld[i] && m_cnt[i] < MAX) exp_rdy[i] = 1'b1;
        end
        exp_rsp = '0;
        exp_z   = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rsp[pend[0].tag] = 1'b1;
            exp_z = 8'(pend[0].z);
        end
        exp_busy = 1'b0;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_busy = 1'b1;
        got_z = (exp_rsp != 4'b0000) ? bus.rsp_z : 8'h00;
    endfunction

    // Commit the cycle: retire the returning result, accept the granted op.
    function automatic void advance();
        if (exp_rsp != 4'b0000) begin
            m_cnt[pend[0].tag]--;
            void'(pend.pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                op_t o;
                o.tag = i;
                o.z   = (int'(bus.req_a[i*W +: W]) + int'(bus.req_b[i*W +: W])) % M;
                o.due = cyc + LAT;
                pend.push_back(o);
                m_cnt[i]++;
                m_rr = (i + 1) % N;
            end
        end
        cyc++;
    endfunction

    function automatic void rand_operands();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = 8'($urandom_range(0, M - 1));
            bus.req_b[i*W +: W] = 8'($urandom_range(0, M - 1));
        end
    endfunction

    task automatic test_reset();
        s_rst_n = 1'b0;
        bus.req_vld = '0;
        rand_operands();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_rdy, bus.rsp_avail, bus.busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%b rsp=%b busy=%b required all zero", bus.req_rdy, bus.rsp_avail, bus.busy);
        end
        s_rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({bus.req_rdy, bus.rsp_avail, bus.busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b rsp=%b busy=%b required all zero", bus.req_rdy, bus.rsp_avail, bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        logic [7:0] va [4] = '{8'd200, 8'd250, 8'd0, 8'd125};
        logic [7:0] vb [4] = '{8'd100, 8'd0,   8'd0, 8'd126};
        logic [7:0] vz [4] = '{8'd49,  8'd250, 8'd0, 8'd0};
        int idx = 0;
        int r = 0;
        for (int k = 0; k < 16; k++) begin
            bus.req_vld = (idx < 4) ? 4'b0001 : 4'b0000;
            if (idx < 4) begin
                bus.req_a[0 +: W] = va[idx];
                bus.req_b[0 +: W] = vb[idx];
            end
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL arith cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            if (bus.rsp_avail != 4'b0000 && r < 4) begin
                checks++;
                if (bus.rsp_avail !== 4'b0001 || bus.rsp_z !== vz[r]) begin
                    errors++;
                    $display("FAIL arith_vec%0d rsp=%b z=%0d required rsp=0001 z=%0d", r, bus.rsp_avail, bus.rsp_z, vz[r]);
                end
                r++;
            end
            if (bus.req_rdy[0] && idx < 4) idx++;
            advance();
            @(posedge clk);
            #1;
        end
        checks++;
        if (r != 4) begin
            errors++;
            $display("FAIL arith_count results=%0d required 4", r);
        end
    endtask

    task automatic test_rr_all();
        logic [3:0] prev = '0;
        for (int k = 0; k < 20; k++) begin
            bus.req_vld = (k < 16) ? 4'b1111 : 4'b0000;
            rand_operands();
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL rr_all cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            if (k > 0 && k < 16) begin
                checks++;
                if (bus.req_rdy !== {prev[2:0], prev[3]}) begin
                    errors++;
                    $display("FAIL rr_rotate cyc=%0d rdy=%b required %b", cyc, bus.req_rdy, {prev[2:0], prev[3]});
                end
            end
            prev = bus.req_rdy;
            advance();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_credit();
        logic [9:0] pat = 10'b1100110011;
        for (int k = 0; k < 14; k++) begin
            bus.req_vld = (k < 10) ? 4'b0010 : 4'b0000;
            rand_operands();
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL credit cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            if (k < 10) begin
                checks++;
                if (bus.req_rdy !== {2'b00, pat[9-k], 1'b0}) begin
                    errors++;
                    $display("FAIL credit_pattern step=%0d rdy=%b required %b", k, bus.req_rdy, {2'b00, pat[9-k], 1'b0});
                end
            end
            advance();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rr_skip();
        logic [3:0] vseq [5] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b1101};
        logic [3:0] gseq [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b1000};
        for (int k = 0; k < 9; k++) begin
            bus.req_vld = (k < 5) ? vseq[k] : 4'b0000;
            rand_operands();
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL rr_skip cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            if (k < 5) begin
                checks++;
                if (bus.req_rdy !== gseq[k]) begin
                    errors++;
                    $display("FAIL rr_skip_order step=%0d rdy=%b required %b", k, bus.req_rdy, gseq[k]);
                end
            end
            advance();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            bus.req_vld = (k < 194) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rand_operands();
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL random cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            advance();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_inflight();
        for (int k = 0; k < 3; k++) begin
            bus.req_vld = 4'b0111;
            rand_operands();
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL inflight cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            advance();
            @(posedge clk);
            #1;
        end
        bus.req_vld = '0;
        s_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_rdy, bus.rsp_avail, bus.busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid rdy=%b rsp=%b busy=%b required all zero", bus.req_rdy, bus.rsp_avail, bus.busy);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_avail, bus.busy} !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold rsp=%b busy=%b required zero", bus.rsp_avail, bus.busy);
            end
        end
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            bus.req_vld = (k == 5) ? 4'b0110 : 4'b0000;
            rand_operands();
            @(negedge clk);
            predict();
            checks++;
            if ({bus.req_rdy, bus.rsp_avail, got_z, bus.busy} !== {exp_rdy, exp_rsp, exp_z, exp_busy}) begin
                errors++;
                $display("FAIL post_reset cyc=%0d rdy=%b/%b rsp=%b/%b z=%0d/%0d busy=%b/%b", cyc,
                         bus.req_rdy, exp_rdy, bus.rsp_avail, exp_rsp, got_z, exp_z, bus.busy, exp_busy);
            end
            if (k == 5) begin
                checks++;
                if (bus.req_rdy !== 4'b0010) begin
                    errors++;
                    $display("FAIL post_reset_grant rdy=%b required 0010", bus.req_rdy);
                end
            end
            advance();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        s_rst_n     = 1'b0;
        bus.req_vld = '0;
        bus.req_a   = '0;
        bus.req_b   = '0;
        model_reset();
        test_reset();
        test_arith();
        test_rr_all();
        test_credit();
        test_rr_skip();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
